// File: rtl/serial_pkg.sv
// serial_pkg: shared FSM states, default oversampling and tick divider for the serial blocks
package serial_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;
  localparam int OVERSAMPLE_DEF = 10;
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction
endpackage

// File: rtl/serial_baud_tick.sv
// baud_tick_gen: DIV-clock sample tick generator, held at phase zero while clr_i is high
module baud_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TOP = W'(DIV - 1);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk)
    if (rst || clr_i) cnt_q <= '0;
    else cnt_q <= cnt_q == TOP ? '0 : cnt_q + 1'b1;
  assign tick_o = !clr_i && cnt_q == TOP;
endmodule

// File: rtl/serial_rx.sv
// serial_rx: oversampling 8N1 UART receiver; define SERIAL_RX_MAJORITY_EN for 2-of-3 bit voting
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 1000000,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rxReady,
  output logic [7:0] rxData,
  output logic       rxFrameErr,
  output logic       rxBusy,
  output logic [7:0] rxErrCount
);
  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int SW = $clog2(OVERSAMPLE);
  if (DIV < 1) begin : g_div_chk
    $error("serial_rx: CLK_HZ/(BAUD*OVERSAMPLE) must be >= 1");
  end
  if (OVERSAMPLE < 4 || OVERSAMPLE % 2 != 0) begin : g_os_chk
    $error("serial_rx: OVERSAMPLE must be even and >= 4");
  end
  state_e state_q, state_d;
  logic [1:0] sync_q;
  logic [SW-1:0] sc_q, sc_d;
  logic [2:0] bi_q, bi_d;
  logic [7:0] sh_q, sh_d, data_q, data_d, ecnt_q, ecnt_d;
  logic ready_q, ready_d, ferr_q, ferr_d, stop_hit;
  logic rxs, tick, bit_v;
  assign rxs = sync_q[1];
`ifdef SERIAL_RX_MAJORITY_EN
  localparam int LAG = 1;
  logic [1:0] hist_q;
  always_ff @(posedge clk)
    if (reset) hist_q <= 2'b11;
    else if (tick) hist_q <= {hist_q[0], rxs};
  assign bit_v = (hist_q[1] & hist_q[0]) | (rxs & (hist_q[1] | hist_q[0]));
`else
  localparam int LAG = 0;
  assign bit_v = rxs;
`endif
  // voting commits one tick late, so the start decision moves and every later centre follows
  localparam logic [SW-1:0] START_C = SW'(OVERSAMPLE / 2 - 1 + LAG);
  localparam logic [SW-1:0] BIT_C = SW'(OVERSAMPLE - 1);
  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst   (reset),
    .clr_i (state_q == IDLE),
    .tick_o(tick)
  );
  always_ff @(posedge clk)
    if (reset) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      sc_q    <= '0;
      bi_q    <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      ecnt_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      sc_q    <= sc_d;
      bi_q    <= bi_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      ecnt_q  <= ecnt_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
    end
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    bi_d    = bi_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: if (!rxs) begin
        state_d = START;
        sc_d    = '0;
      end
      START: if (tick) begin
        sc_d = sc_q + 1'b1;
        if (sc_q == START_C) begin
          state_d = bit_v ? IDLE : DATA;
          sc_d    = '0;
          bi_d    = '0;
        end
      end
      DATA: if (tick) begin
        sc_d = sc_q == BIT_C ? '0 : sc_q + 1'b1;
        if (sc_q == BIT_C) begin
          sh_d = {bit_v, sh_q[7:1]};
          bi_d = bi_q + 3'd1;
          state_d = bi_q == 3'd7 ? STOP : DATA;
        end
      end
      STOP: if (tick) begin
        sc_d = sc_q == BIT_C ? '0 : sc_q + 1'b1;
        if (sc_q == BIT_C) state_d = bit_v ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    stop_hit = state_q == STOP && tick && sc_q == BIT_C;
    ready_d  = stop_hit && bit_v;
    ferr_d   = stop_hit && !bit_v;
    data_d   = ready_d ? sh_q : data_q;
    ecnt_d   = ferr_d && ecnt_q != 8'hFF ? ecnt_q + 8'd1 : ecnt_q;
    rxBusy   = state_q != IDLE;
  end
  assign rxReady    = ready_q;
  assign rxFrameErr = ferr_q;
  assign rxData     = data_q;
  assign rxErrCount = ecnt_q;
endmodule
